// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: spike traces, clamped weight learning, registered current.
// Depression is built only when STDP_DEPRESSION_EN is defined.
module stdp_synapse #(
   parameter logic [7:0] W_INIT    = 8'd64,
   parameter logic [3:0] TRACE_MAX = 4'd15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pre_spike,
   input  logic       post_spike,
   input  logic       learn_en,
   input  logic       wload,
   input  logic [7:0] wdata,
   output logic [7:0] current,
   output logic [7:0] weight,
   output logic [3:0] pre_trace,
   output logic [3:0] post_trace
);

   logic [3:0]        pre_trace_nxt;
   logic [3:0]        post_trace_nxt;
   logic [3:0]        ltp;
   logic [3:0]        ltd;
   logic signed [9:0] wsum;
   logic [7:0]        wclamp;
   logic [7:0]        weight_nxt;
   logic [7:0]        current_nxt;

   always_comb begin
      pre_trace_nxt = pre_trace;
      if (pre_spike)
         pre_trace_nxt = TRACE_MAX;
      else if (pre_trace != 4'd0)
         pre_trace_nxt = pre_trace - 4'd1;
   end

   always_comb begin
      post_trace_nxt = post_trace;
      if (post_spike)
         post_trace_nxt = TRACE_MAX;
      else if (post_trace != 4'd0)
         post_trace_nxt = post_trace - 4'd1;
   end

   // Both terms use the traces as they stood before this edge.
   assign ltp = post_spike ? (pre_trace >> 1) : 4'd0;
`ifdef STDP_DEPRESSION_EN
   assign ltd = pre_spike ? (post_trace >> 1) : 4'd0;
`else
   assign ltd = 4'd0;
`endif

   // 10-bit signed sum so over/underflow is clamped rather than wrapped.
   assign wsum = $signed({2'b00, weight})
               + $signed({6'b000000, ltp})
               - $signed({6'b000000, ltd});

   always_comb begin
      wclamp = wsum[7:0];
      if (wsum < 10'sd0)
         wclamp = 8'd0;
      else if (wsum > 10'sd255)
         wclamp = 8'd255;
   end

   always_comb begin
      weight_nxt = weight;
      if (wload)
         weight_nxt = wdata;
      else if (learn_en)
         weight_nxt = wclamp;
   end

   assign current_nxt = pre_spike ? weight : 8'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         weight     <= W_INIT;
         pre_trace  <= 4'd0;
         post_trace <= 4'd0;
         current    <= 8'd0;
      end else begin
         weight     <= weight_nxt;
         pre_trace  <= pre_trace_nxt;
         post_trace <= post_trace_nxt;
         current    <= current_nxt;
      end
   end

endmodule

// File: doc/stdp_synapse.md
STDP_SYNAPSE -- requirements
Module: stdp_synapse

Interface
REQ-001 The module SHALL use parameter W_INIT, default 8'd64, as the weight value loaded at reset.
REQ-002 The module SHALL use parameter TRACE_MAX, default 4'd15, as the value loaded into a trace on a spike.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The module SHALL have port pre_spike, input, 1 bit, the presynaptic spike; one pulse per high cycle.
REQ-006 The module SHALL have port post_spike, input, 1 bit, the postsynaptic spike from the downstream neuron's spike output.
REQ-007 The module SHALL have port learn_en, input, 1 bit; while high, weight plasticity is enabled.
REQ-008 The module SHALL have port wload, input, 1 bit, the weight load strobe.
REQ-009 The module SHALL have port wdata, input, 8 bits, the weight load value.
REQ-010 The module SHALL have port current, output, 8 bits, a registered synaptic current driving the neuron's current input.
REQ-011 The module SHALL have port weight, output, 8 bits, the registered synaptic weight, unsigned.
REQ-012 The module SHALL have port pre_trace, output, 4 bits, the registered presynaptic trace.
REQ-013 The module SHALL have port post_trace, output, 4 bits, the registered postsynaptic trace.

Function
REQ-014 On each edge, pre_trace SHALL become TRACE_MAX when pre_spike is high; otherwise it SHALL decrement by 1, saturating at 0.
REQ-015 post_trace SHALL follow the same rule as pre_trace, driven by post_spike.
REQ-016 Potentiation SHALL be ltp = (post_spike ? pre_trace>>1 : 0), using pre_trace's value before the current edge.
REQ-017 Depression SHALL be ltd = (pre_spike ? post_trace>>1 : 0), using post_trace's value before the current edge.
REQ-018 When learn_en is high and wload is low, weight SHALL become clamp(weight + ltp - ltd, 0, 255).
REQ-019 The clamp SHALL be evaluated in at least 10-bit signed arithmetic, with no wrap-around.
REQ-020 When pre_spike and post_spike are high in the same cycle, both ltp and ltd SHALL apply in that single update.
REQ-021 When learn_en is low, weight SHALL hold; traces SHALL keep running.
REQ-022 wload SHALL have priority over learning: weight SHALL become wdata on that edge, and ltp and ltd SHALL be discarded.
REQ-023 The current update SHALL have 1-cycle latency: current SHALL become (pre_spike ? weight : 0), where weight is its value before the edge.
REQ-024 current SHALL be 0 in every cycle following an edge at which pre_spike was low.
REQ-025 A weight change SHALL be visible on the weight output one cycle after the triggering edge.

Reset
REQ-026 When rst_n is low at an edge, weight SHALL become W_INIT, pre_trace and post_trace SHALL become 0, and current SHALL become 0.
REQ-027 Reset SHALL override wload, learn_en and any spikes, including when asserted mid-trace.

Configuration
REQ-028 The macro STDP_DEPRESSION_EN SHALL control depression.
REQ-029 When STDP_DEPRESSION_EN is defined, ltd SHALL be as in REQ-017.
REQ-030 When STDP_DEPRESSION_EN is undefined, ltd SHALL be constant 0, the weight SHALL only potentiate, and post_trace SHALL still be computed and output.

Verification
REQ-031 Bench scenario (LTP): reset, learn_en=1, pre_spike pulse at edge N, post_spike pulse at edge N+3 -> pre_trace is 13 at edge N+3; weight goes 64->70 after edge N+3.
REQ-032 Bench scenario (LTD, STDP_DEPRESSION_EN defined): post_spike pulse at edge N, pre_spike pulse at edge N+1 -> weight goes 64->57.
REQ-033 Bench scenario (LTD, STDP_DEPRESSION_EN undefined): the REQ-032 stimulus -> weight stays 64.
REQ-034 Bench scenario (saturation): wload with wdata=250; pre_spike at edge N, post_spike at edge N+1 -> weight 255, not 1.
REQ-035 Bench scenario (saturation, STDP_DEPRESSION_EN defined): wload with wdata=3, then post_spike then pre_spike -> weight 0.
REQ-036 Bench scenario (current/freeze): learn_en=0, weight=64, pre_spike at edge N -> current=64 for exactly one cycle and 0 afterwards; weight unchanged.
REQ-037 Bench scenario (current/freeze): the REQ-036 stimulus with wload and pre_spike at the same edge -> current shows the old weight and weight becomes wdata.
REQ-038 Bench scenario (reset mid-operation): rst_n low at edge N+2 after pre_spike at edge N -> traces 0, weight 64, current 0; a subsequent post_spike causes no change.
